// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
//   Shared types and defaults for the hazard / stall controller.
//   - state_e  : controller FSM state encoding
//   - ctrl_t   : bundle of the six pipeline control outputs
//   - REG_ADDR_W_DEF / CNT_W_DEF : default parameter values
// ---------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_freeze;
    logic ifid_freeze;
    logic hazard_detected;
    logic if_flush;
    logic exe_freeze;
    logic mem_freeze;
  } ctrl_t;

endpackage

// File: rtl/hazard_stall_ctrl_compare.sv
// ---------------------------------------------------------------------------
// hazard_compare
//   RAW match of the ID-stage source registers against one downstream
//   destination register.
//   Ports:
//     src1, src2 : ID source register addresses
//     two_src    : instruction actually reads src2
//     dest       : downstream destination register
//     wb_en      : downstream instruction writes back
//     match      : RAW dependence exists
// ---------------------------------------------------------------------------
module hazard_compare
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  two_src,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  wb_en,
  output logic                  match
);

  logic dest_live;
  logic hit1;
  logic hit2;

  // Register 0 is hard-wired zero, so writes to it never create a dependence.
  assign dest_live = wb_en && (dest != '0);
  assign hit1      = (src1 == dest);
  assign hit2      = two_src && (src2 == dest);
  assign match     = dest_live && (hit1 || hit2);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//   Pipeline hazard / stall controller for a 5-stage in-order pipeline with
//   branch resolution in ID.
//   Ports:
//     clk, rst           : clock, asynchronous active-low reset (released
//                          synchronously to clk by the reset source)
//     id_src1/2, id_two_src, id_is_branch, id_br_taken : ID-stage info
//     exe_dest, exe_wb_en, exe_mem_r_en               : EXE-stage info
//     mem_dest, mem_wb_en                             : MEM-stage info
//     mem_req, mem_ready : data-memory handshake
//     pc_freeze, ifid_freeze : hold PC and IF/ID
//     hazard_detected    : bubble into ID/EXE
//     if_flush           : squash IF/ID on taken branch
//     exe_freeze, mem_freeze : hold ID/EXE and EXE/MEM during memory wait
//     stall_cnt          : saturating count of cycles with pc_freeze=1
//   Configuration macro: FORWARDING_EN
//     defined   : only load-use (EXE load) stalls; branches in ID still stall
//                 on any EXE/MEM match since they compare before forwarding.
//     undefined : any EXE or MEM RAW match stalls.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_is_branch,
  input  logic                  id_br_taken,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_freeze,
  output logic                  ifid_freeze,
  output logic                  hazard_detected,
  output logic                  if_flush,
  output logic                  exe_freeze,
  output logic                  mem_freeze,
  output logic [CNT_W-1:0]      stall_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  ctrl_t            ctrl;

  logic exe_match;
  logic mem_match;
  logic stall_haz;
  logic mem_stall;

  // -------------------------------------------------------------------------
  // Source / destination comparators
  // -------------------------------------------------------------------------
  hazard_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_exe (
    .src1    (id_src1),
    .src2    (id_src2),
    .two_src (id_two_src),
    .dest    (exe_dest),
    .wb_en   (exe_wb_en),
    .match   (exe_match)
  );

  hazard_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_mem (
    .src1    (id_src1),
    .src2    (id_src2),
    .two_src (id_two_src),
    .dest    (mem_dest),
    .wb_en   (mem_wb_en),
    .match   (mem_match)
  );

`ifdef FORWARDING_EN
  // ALU results are forwarded; only a load in EXE cannot be. A branch
  // compares in ID, ahead of the forwarding muxes, so it waits on any match.
  assign stall_haz = (exe_match && exe_mem_r_en) ||
                     (id_is_branch && (exe_match || mem_match));
`else
  logic unused_cfg;
  assign unused_cfg = id_is_branch ^ exe_mem_r_en;
  assign stall_haz  = exe_match || mem_match;
`endif

  assign mem_stall = mem_req && !mem_ready;

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    if (mem_stall) begin
      // Memory wait outranks everything and freezes the whole front end.
      state_d          = MEM_WAIT;
      ctrl.pc_freeze   = 1'b1;
      ctrl.ifid_freeze = 1'b1;
      ctrl.exe_freeze  = 1'b1;
      ctrl.mem_freeze  = 1'b1;
    end else begin
      unique case (state_q)
        // The ID slot in this cycle is the squashed one: its sources and
        // branch outcome are not real, so nothing is acted on.
        BR_FLUSH: state_d = RUN;
        // RUN, LU_STALL and the MEM_WAIT exit cycle all evaluate the
        // instruction now in ID the same way; a branch that was held by a
        // stall gets its flush on the cycle the stall clears.
        RUN, LU_STALL, MEM_WAIT: begin
          if (stall_haz) begin
            state_d              = LU_STALL;
            ctrl.pc_freeze       = 1'b1;
            ctrl.ifid_freeze     = 1'b1;
            ctrl.hazard_detected = 1'b1;
          end else if (id_br_taken) begin
            state_d       = BR_FLUSH;
            ctrl.if_flush = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Saturating stall counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl.pc_freeze && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are forced low while reset is held, independent of inputs.
  assign pc_freeze       = rst && ctrl.pc_freeze;
  assign ifid_freeze     = rst && ctrl.ifid_freeze;
  assign hazard_detected = rst && ctrl.hazard_detected;
  assign if_flush        = rst && ctrl.if_flush;
  assign exe_freeze      = rst && ctrl.exe_freeze;
  assign mem_freeze      = rst && ctrl.mem_freeze;
  assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  localparam int AW = 5;

  typedef struct {
    logic [AW-1:0] src1, src2;
    logic          two_src, is_br, br_taken;
    logic [AW-1:0] exe_dest;
    logic          exe_wb, exe_rd;
    logic [AW-1:0] mem_dest;
    logic          mem_wb, mem_req, mem_ready;
  } in_t;

  // expected bits: {pc, ifid, hazard, flush, exe, mem}
  typedef struct {
    in_t        i;
    logic [5:0] e;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_two_src, id_is_branch, id_br_taken, exe_wb_en, exe_mem_r_en;
  logic mem_wb_en, mem_req, mem_ready;
  logic pc_freeze, ifid_freeze, hazard_detected, if_flush, exe_freeze, mem_freeze;
  logic [15:0] stall_cnt;
  logic pc_freeze_s, ifid_freeze_s, hazard_detected_s, if_flush_s, exe_freeze_s, mem_freeze_s;
  logic [2:0] stall_cnt_s;

  int total = 0;
  int bad   = 0;
  bit sq    = 0;   // model: this cycle's ID slot was squashed by a flush
  int cnt   = 0;   // model: stall cycles seen

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_is_branch(id_is_branch), .id_br_taken(id_br_taken),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze), .ifid_freeze(ifid_freeze), .hazard_detected(hazard_detected),
    .if_flush(if_flush), .exe_freeze(exe_freeze), .mem_freeze(mem_freeze),
    .stall_cnt(stall_cnt)
  );

  // Narrow counter instance to exercise saturation.
  hazard_stall_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_is_branch(id_is_branch), .id_br_taken(id_br_taken),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze_s), .ifid_freeze(ifid_freeze_s), .hazard_detected(hazard_detected_s),
    .if_flush(if_flush_s), .exe_freeze(exe_freeze_s), .mem_freeze(mem_freeze_s),
    .stall_cnt(stall_cnt_s)
  );

  function automatic in_t mk(int s1, int s2, int ts, int br, int tk, int ed, int ew,
                             int er, int md, int mw, int mq, int mr);
    in_t v;
    v.src1 = AW'(s1); v.src2 = AW'(s2); v.two_src = ts[0]; v.is_br = br[0];
    v.br_taken = tk[0]; v.exe_dest = AW'(ed); v.exe_wb = ew[0]; v.exe_rd = er[0];
    v.mem_dest = AW'(md); v.mem_wb = mw[0]; v.mem_req = mq[0]; v.mem_ready = mr[0];
    return v;
  endfunction

  // Reference: priority rules applied to the current inputs plus one bit of
  // history (whether the previous cycle issued a flush).
  function automatic logic [5:0] model(in_t v, bit squashed);
    bit em, mm, stall;
    em = v.exe_wb && (v.exe_dest != 0) &&
         ((v.src1 == v.exe_dest) || (v.two_src && (v.src2 == v.exe_dest)));
    mm = v.mem_wb && (v.mem_dest != 0) &&
         ((v.src1 == v.mem_dest) || (v.two_src && (v.src2 == v.mem_dest)));
`ifdef FORWARDING_EN
    stall = (em && v.exe_rd) || (v.is_br && (em || mm));
`else
    stall = em || mm;
`endif
    if (v.mem_req && !v.mem_ready) return 6'b110011;
    if (squashed)                  return 6'b000000;
    if (stall)                     return 6'b111000;
    if (v.br_taken)                return 6'b000100;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] outs();
    return {pc_freeze, ifid_freeze, hazard_detected, if_flush, exe_freeze, mem_freeze};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(in_t v);
    id_src1 = v.src1; id_src2 = v.src2; id_two_src = v.two_src;
    id_is_branch = v.is_br; id_br_taken = v.br_taken;
    exe_dest = v.exe_dest; exe_wb_en = v.exe_wb; exe_mem_r_en = v.exe_rd;
    mem_dest = v.mem_dest; mem_wb_en = v.mem_wb; mem_req = v.mem_req; mem_ready = v.mem_ready;
  endtask

  task automatic step(string name, in_t v, bit use_te, logic [5:0] te);
    logic [5:0] exp;
    @(negedge clk);
    drive(v);
    #2;
    exp = model(v, sq);
    chk({name, " out"}, 32'(outs()), 32'(exp));
    if (use_te) chk({name, " tbl"}, 32'(outs()), 32'(te));
    chk({name, " cnt"}, 32'(stall_cnt), cnt);
    chk({name, " sat"}, 32'(stall_cnt_s), (cnt > 7) ? 7 : cnt);
    @(posedge clk);
    sq = exp[2];
    if (exp[5] && cnt < 65535) cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    #2;
    chk("rst outs", 32'(outs()), 0);
    chk("rst cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    sq  = 0;
    cnt = 0;
  endtask

  rec_t tbl[16];
  in_t  idle, mw, v;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,0,0,0,0);
    mw   = mk(0,0,0,0,0,0,0,0,0,0,1,0);
    //             s1 s2 ts br tk ed ew er md mw mq mr
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 6'b000000};
    tbl[1]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 6'b000000}; // r0 never hazards
    tbl[2]  = '{mk(1, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0), 6'b000000}; // src2 not read
    tbl[3]  = '{mk(1, 3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0), 6'b111000}; // src2 read
    tbl[4]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 6'b000000};
    tbl[5]  = '{mk(7, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0), 6'b111000}; // MEM match
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 6'b000000};
    tbl[7]  = '{mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 6'b000100}; // taken branch
    tbl[8]  = '{mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 6'b000000}; // squashed slot
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 6'b000000};
    tbl[10] = '{mk(4, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0), 6'b111000}; // branch hazard
    tbl[11] = '{mk(4, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0), 6'b111000};
    tbl[12] = '{mk(4, 0, 0, 1, 1, 4, 0, 0, 0, 0, 0, 0), 6'b000100}; // cleared -> flush
    tbl[13] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 6'b000000};
    tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 6'b110011}; // mem wait
    tbl[15] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 6'b000000}; // mem done

    rst = 1'b0;
    drive(idle);
    do_reset();

    for (int k = 0; k < 16; k++) step($sformatf("vec%0d", k), tbl[k].i, 1'b1, tbl[k].e);
    #2 chk("tbl stall_cnt", 32'(stall_cnt), 5);

    // Load-use: one stall cycle.
    do_reset();
    step("lu", mk(5,0,0,0,0,5,1,1,0,0,0,0), 1'b1, 6'b111000);
    step("lu clr", idle, 1'b1, 6'b000000);
    #2 chk("lu stall_cnt", 32'(stall_cnt), 1);

    // Memory wait for four cycles, released on the fifth.
    do_reset();
    for (int k = 0; k < 4; k++) step($sformatf("mw%0d", k), mw, 1'b1, 6'b110011);
    step("mw rel", mk(0,0,0,0,0,0,0,0,0,0,1,1), 1'b1, 6'b000000);
    #2 chk("mw stall_cnt", 32'(stall_cnt), 4);

    // Reset asserted in the middle of a memory wait.
    do_reset();
    step("mr0", mw, 1'b1, 6'b110011);
    step("mr1", mw, 1'b1, 6'b110011);
    @(negedge clk);
    drive(mk(5,0,0,1,1,5,1,1,0,0,1,0));
    #2 rst = 1'b0;
    #1;
    chk("midrst outs", 32'(outs()), 0);
    chk("midrst cnt", 32'(stall_cnt), 0);
    @(posedge clk);
    #2 chk("inrst outs", 32'(outs()), 0);
    @(negedge clk);
    drive(idle);
    rst = 1'b1;
    sq  = 0;
    cnt = 0;
    step("postrst", idle, 1'b1, 6'b000000);
    step("postrst br", mk(0,0,0,1,1,0,0,0,0,0,0,0), 1'b1, 6'b000100);

    // Randomized against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v.src1      = AW'($urandom_range(0, 3));
      v.src2      = AW'($urandom_range(0, 3));
      v.two_src   = 1'($urandom_range(0, 1));
      v.is_br     = 1'($urandom_range(0, 1));
      v.br_taken  = ($urandom_range(0, 2) == 0);
      v.exe_dest  = AW'($urandom_range(0, 3));
      v.exe_wb    = 1'($urandom_range(0, 1));
      v.exe_rd    = 1'($urandom_range(0, 1));
      v.mem_dest  = AW'($urandom_range(0, 3));
      v.mem_wb    = 1'($urandom_range(0, 1));
      v.mem_req   = ($urandom_range(0, 3) == 0);
      v.mem_ready = 1'($urandom_range(0, 1));
      step("rnd", v, 1'b0, 6'b000000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-file address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  in  1  system clock; the block uses one clock.
REQ-004 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port id_src1  in  REG_ADDR_W  ID source-1 register address.
REQ-006 SHALL have port id_src2  in  REG_ADDR_W  ID source-2 register address.
REQ-007 SHALL have port id_two_src  in  1  ID instruction reads src2: not immediate, or store/BNE.
REQ-008 SHALL have port id_is_branch  in  1  ID holds a branch; branch compares in ID.
REQ-009 SHALL have port id_br_taken  in  1  ID branch condition true.
REQ-010 SHALL have port exe_dest, exe_wb_en, exe_mem_r_en  in  REG_ADDR_W/1/1  EXE-stage destination, write-back enable, load flag.
REQ-011 SHALL have port mem_dest, mem_wb_en  in  REG_ADDR_W/1  MEM-stage destination and write-back enable.
REQ-012 SHALL have port mem_req, mem_ready  in  1/1  data-memory access in progress; memory done.
REQ-013 SHALL have port pc_freeze, ifid_freeze  out  1/1  hold PC and IF/ID register.
REQ-014 SHALL have port hazard_detected  out  1  insert bubble into ID/EXE (zero control signals).
REQ-015 SHALL have port if_flush  out  1  squash IF/ID on a taken branch.
REQ-016 SHALL have port exe_freeze, mem_freeze  out  1/1  hold ID/EXE and EXE/MEM during a memory wait.
REQ-017 SHALL have port stall_cnt  out  CNT_W  count of stall cycles.

Function
REQ-018 SHALL have FSM states RUN, LU_STALL, BR_FLUSH, MEM_WAIT.
REQ-019 SHALL detect a RAW hazard when a source matches a destination with wb_en=1 and the address is non-zero; src2 counts only when id_two_src=1.
REQ-020 SHALL apply transition priority MEM_WAIT > RAW stall > branch flush.
REQ-021 From any state, mem_req=1 and mem_ready=0 SHALL go to MEM_WAIT.
- Outputs: all freezes =1; hazard_detected=0; if_flush=0.
REQ-022 MEM_WAIT SHALL exit on mem_ready=1 to RUN, with freezes released in that same cycle.
REQ-023 A stall hazard in RUN SHALL assert, in the same cycle:
- combinational pc_freeze=ifid_freeze=hazard_detected=1;
- next state LU_STALL.
REQ-024 LU_STALL SHALL re-evaluate the hazard each cycle:
- still present: stay;
- cleared: return to RUN.
REQ-025 id_is_branch with a hazard on its sources SHALL stall; if_flush is suppressed while the stall lasts.
REQ-026 id_br_taken=1 in RUN with no hazard SHALL assert if_flush=1 for exactly one cycle and enter BR_FLUSH.
REQ-027 BR_FLUSH SHALL last one cycle with if_flush=0, then go to RUN; a new taken branch in that cycle is ignored, because it is the squashed slot.
REQ-028 stall_cnt SHALL increment each cycle pc_freeze=1, saturating at all-ones, with no wrap-around.
REQ-029 Outputs SHALL be combinational from state and inputs; only state and stall_cnt are registered.

Reset
REQ-030 rst=0 SHALL asynchronously force state=RUN and stall_cnt=0.
REQ-031 While rst=0, all outputs SHALL be 0.
REQ-032 Reset deassertion SHALL be synchronous to clk.
REQ-033 Reset mid-MEM_WAIT or mid-LU_STALL SHALL abandon the operation; there is no pending state.

Configuration
REQ-034 Macro FORWARDING_EN defined: the stall hazard SHALL be a load-use hazard only, i.e. an exe_mem_r_en=1 match against exe_dest.
- The mem_dest comparison is ignored, except for id_is_branch, which still stalls on any exe/mem match.
REQ-035 FORWARDING_EN undefined: any RAW match against exe_dest or mem_dest SHALL stall.

Structure
REQ-036 A shared package SHALL hold the FSM state enum, REG_ADDR_W, and CNT_W defaults.
REQ-037 One sub-module, hazard_compare, SHALL perform the source/destination match, instanced twice (EXE, MEM).

Verification
REQ-038 Bench SHALL cover: load exe_dest=5, exe_mem_r_en=1, id_src1=5 -> pc_freeze=hazard_detected=1 for 1 cycle, stall_cnt=1.
REQ-039 Bench SHALL cover: id_src2=3, id_two_src=0, exe_dest=3, wb_en=1, FORWARDING_EN undefined -> no stall.
REQ-040 Bench SHALL cover: id_br_taken=1, no hazard -> if_flush=1 one cycle, next cycle if_flush=0 even with id_br_taken=1.
REQ-041 Bench SHALL cover: mem_req=1, mem_ready=0 for 4 cycles, then 1 -> all freezes=1 for 4 cycles, released on cycle 5, stall_cnt=4.
REQ-042 Bench SHALL cover: dest=0 with wb_en=1 matching src=0 -> no stall.
REQ-043 Bench SHALL cover: rst=0 asserted mid-MEM_WAIT -> outputs 0 immediately; state=RUN, stall_cnt=0 after release.
